// File: rtl/etai_arbiter.sv
// Two-requester round-robin front end for a shared ETAI adder.
// Registers operands, captures the approximate sum and returns it.
module etai_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  output logic [N-1:0] add_x,
  output logic [N-1:0] add_y,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         busy,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         id_q, id_d;
  logic [N-1:0] add_x_q, add_x_d;
  logic [N-1:0] add_y_q, add_y_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic [15:0]  cnt0_q, cnt0_d;
  logic [15:0]  cnt1_q, cnt1_d;
  logic         gnt;
  logic         acc;

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt = ptr_q;
    unique case (1'b1)
      (req0_valid && !req1_valid): gnt = 1'b0;
      (!req0_valid && req1_valid): gnt = 1'b1;
      default:                     gnt = ptr_q;
    endcase
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !gnt;
  assign req1_ready = (state_q == IDLE) && req1_valid && gnt;
  assign acc        = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    add_x_d = add_x_q;
    add_y_d = add_y_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = EXEC;
          ptr_d   = ~gnt;
          id_d    = gnt;
          add_x_d = gnt ? req1_x : req0_x;
          add_y_d = gnt ? req1_y : req0_y;
        end
      end
      EXEC: begin
        state_d = RESP;
        sum_d   = add_s;
        cout_d  = add_cout;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (id_q) cnt1_d = cnt1_q + 16'd1;
          else      cnt0_d = cnt0_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      add_x_q <= '0;
      add_y_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      add_x_q <= add_x_d;
      add_y_q <= add_y_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != IDLE);
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_etai_arbiter.sv
// Directed and random bench for etai_arbiter against a
// transaction-level model and a behavioural ETAI12 adder.
module tb_etai_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_x, req0_y;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_x, req1_y;
  logic [15:0] add_x, add_y, add_s;
  logic        add_cout;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout, busy;
  logic [15:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  // model: one outstanding transaction at most
  bit          m_pend, m_exec, m_last, m_rid;
  logic [15:0] m_ax, m_ay, m_sum;
  logic        m_cout;
  logic [15:0] m_cnt [2];
  bit          obs_ids [$];

  always #5 clk = ~clk;

  etai_arbiter #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y),
    .add_x(add_x), .add_y(add_y),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // ETAI12: exact upper nibble, lower 12 bits xor until the
  // first 1/1 pair from the top, then all ones below it.
  function automatic logic [16:0] etai(
    input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  hi;
    logic [11:0] lo;
    bit          sat;
    sat = 0;
    lo  = '0;
    hi  = {1'b0, a[15:12]} + {1'b0, b[15:12]};
    for (int i = 11; i >= 0; i--) begin
      if (sat) lo[i] = 1'b1;
      else if (a[i] && b[i]) begin
        sat   = 1;
        lo[i] = 1'b1;
      end else lo[i] = a[i] ^ b[i];
    end
    return {hi, lo};
  endfunction

  always_comb {add_cout, add_s} = etai(add_x, add_y);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_pend   = 0;
    m_exec   = 0;
    m_last   = 1;
    m_rid    = 0;
    m_ax     = '0;
    m_ay     = '0;
    m_sum    = '0;
    m_cout   = 0;
    m_cnt[0] = '0;
    m_cnt[1] = '0;
  endtask

  task automatic chk_all();
    chk("add_x", add_x, m_ax);
    chk("add_y", add_y, m_ay);
    chk("rsp_valid", rsp_valid, m_pend && !m_exec);
    chk("rsp_id", rsp_id, m_rid);
    chk("rsp_sum", rsp_sum, m_sum);
    chk("rsp_cout", rsp_cout, m_cout);
    chk("busy", busy, m_pend);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("cnt1", cnt1, m_cnt[1]);
  endtask

  // Called at posedge+1; drop clears the accepted request.
  task automatic step(input bit drop);
    bit g, acc;
    g   = (req0_valid && req1_valid) ? !m_last
                                     : req1_valid;
    acc = !m_pend && (req0_valid || req1_valid);
    #2;
    chk("req0_ready", req0_ready, acc && !g);
    chk("req1_ready", req1_ready, acc && g);
    chk_all();
    if (rsp_valid && rsp_ready) obs_ids.push_back(rsp_id);
    if (acc) begin
      m_pend = 1;
      m_exec = 1;
      m_last = g;
      m_rid  = g;
      m_ax   = g ? req1_x : req0_x;
      m_ay   = g ? req1_y : req0_y;
    end else if (m_exec) begin
      {m_cout, m_sum} = etai(m_ax, m_ay);
      m_exec = 0;
    end else if (m_pend && rsp_ready) begin
      m_cnt[m_rid] = m_cnt[m_rid] + 16'd1;
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    if (acc && drop) begin
      if (g) req1_valid = 0;
      else   req0_valid = 0;
    end
  endtask

  task automatic do_reset();
    rst_n      = 0;
    req0_valid = 0;
    req1_valid = 0;
    mreset();
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk_all();
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 0;
    req0_valid = 0;
    req1_valid = 0;
    req0_x     = '0;
    req0_y     = '0;
    req1_x     = '0;
    req1_y     = '0;
    rsp_ready  = 1;
    #1;
    do_reset();

    // single requester
    req0_valid = 1;
    req0_x     = 16'h0800;
    req0_y     = 16'h0801;
    for (int i = 0; i < 4; i++) step(1);
    chk("single_cnt0", cnt0, 16'd1);

    // tie from reset: req0 first, then req1
    do_reset();
    req0_valid = 1;
    req0_x     = 16'hFFFF;
    req0_y     = 16'hFFFF;
    req1_valid = 1;
    req1_x     = 16'h5555;
    req1_y     = 16'hAAAA;
    step(1);
    step(1);
    chk("tie_sum0", rsp_sum, 16'hEFFF);
    chk("tie_cout0", rsp_cout, 1);
    chk("tie_id0", rsp_id, 0);
    step(1);
    step(1);
    step(1);
    chk("tie_sum1", rsp_sum, 16'hFFFF);
    chk("tie_cout1", rsp_cout, 0);
    chk("tie_id1", rsp_id, 1);
    step(1);

    // both held valid: strict alternation
    do_reset();
    obs_ids.delete();
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 18; i++) step(0);
    chk("alt_count", obs_ids.size(), 6);
    foreach (obs_ids[i])
      chk("alt_id", obs_ids[i], i % 2);
    chk("alt_cnt0", cnt0, 16'd3);
    chk("alt_cnt1", cnt1, 16'd3);
    req0_valid = 0;
    req1_valid = 0;
    step(1);

    // consumer stalls in RESP
    req0_valid = 1;
    req0_x     = 16'h1234;
    req0_y     = 16'h0F0F;
    step(1);
    step(1);
    rsp_ready  = 0;
    req1_valid = 1;
    req1_x     = 16'h9999;
    req1_y     = 16'h4444;
    for (int i = 0; i < 5; i++) step(1);
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) step(1);

    // reset while in EXEC
    req0_valid = 1;
    req0_x     = 16'h00FF;
    req0_y     = 16'h0F00;
    step(1);
    do_reset();
    chk("exec_rst_cnt0", cnt0, 16'd0);
    req0_valid = 1;
    for (int i = 0; i < 4; i++) step(1);
    chk("exec_rst_next", cnt0, 16'd1);

    // counter wrap
    force dut.cnt0_q = 16'hFFFF;
    #1;
    release dut.cnt0_q;
    m_cnt[0]   = 16'hFFFF;
    req0_valid = 1;
    step(1);
    step(1);
    step(1);
    step(1);
    chk("wrap_cnt0", cnt0, 16'h0000);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if (!req0_valid && ($urandom % 3 == 0)) begin
        req0_valid = 1;
        req0_x     = 16'($urandom);
        req0_y     = 16'($urandom);
      end else if (req0_valid && ($urandom % 16 == 0))
        req0_valid = 0;
      if (!req1_valid && ($urandom % 3 == 0)) begin
        req1_valid = 1;
        req1_x     = 16'($urandom);
        req1_y     = 16'($urandom);
      end else if (req1_valid && ($urandom % 16 == 0))
        req1_valid = 0;
      rsp_ready = ($urandom % 4) != 0;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/etai_arbiter.md
ETAI_ARBITER -- requirements
Module: etai_arbiter

Interface
REQ-001 Parameter N, default 16: operand and sum width in bits.
REQ-002 clk  input  1: single clock; all state updates on rising edge.
REQ-003 rst_n  input  1: asynchronous, active-low reset.
REQ-004 req0_valid  input  1: requester 0 has an operand pair.
REQ-005 req0_ready  output  1: controller accepts requester 0 this cycle.
REQ-006 req0_x, req0_y  input  N each: requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_x, req1_y: same as REQ-004..006 for requester 1.
REQ-008 add_x, add_y  output  N each: registered operands driven to the shared combinational ETAI adder.
REQ-009 add_s  input  N; add_cout  input  1: sum and carry-out returned by the shared adder.
REQ-010 rsp_valid  output  1: result available.
REQ-011 rsp_ready  input  1: consumer accepts result.
REQ-012 rsp_id  output  1: requester that owns the result.
REQ-013 rsp_sum  output  N; rsp_cout  output  1: captured adder result.
REQ-014 busy  output  1: high in any state other than IDLE.
REQ-015 cnt0, cnt1  output  16 each: completed transactions per requester.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP only.
REQ-017 IDLE: grant chosen combinationally; only the granted requester's ready is high; no ready is high outside IDLE.
REQ-018 Arbitration: if only one valid, grant it; if both valid, grant requester indicated by round-robin pointer ptr.
REQ-019 On accept (valid & ready): load add_x/add_y from the granted requester, latch grant id, set ptr to the other requester, go to EXEC.
REQ-020 Pointer SHALL change only on accept; no change when idle with no requests.
REQ-021 IDLE with no valid: stay in IDLE; add_x/add_y hold last values.
REQ-022 EXEC lasts exactly one cycle; at its end capture add_s into rsp_sum and add_cout into rsp_cout, go to RESP.
REQ-023 RESP: rsp_valid high; rsp_sum, rsp_cout, rsp_id stable until handshake.
REQ-024 On rsp_valid & rsp_ready: increment cnt of rsp_id (wrap 0xFFFF -> 0x0000), return to IDLE.
REQ-025 Latency: accept at edge t -> rsp_valid high after edge t+2; maximum throughput one transaction per 3 cycles with rsp_ready held high.
REQ-026 add_x/add_y SHALL change only on accept, so adder inputs are stable through EXEC.
REQ-027 Controller SHALL NOT modify add_s/add_cout; approximation error is passed through unchanged.
REQ-028 A valid request deasserting before accept is dropped without effect; a request held valid is served within 2 transactions (no starvation).

Reset
REQ-029 rst_n low, including mid-EXEC or mid-RESP: state -> IDLE, ptr -> 0, add_x/add_y/rsp_sum -> 0, rsp_cout/rsp_id/rsp_valid/busy -> 0, cnt0/cnt1 -> 0; in-flight transaction discarded.
REQ-030 After rst_n rises, first accept is possible at the next rising edge.

Verification (shared adder = synthesized ETAI12 netlist, N=16)
REQ-031 Req0 only, x=0x0800, y=0x0801 -> req0_ready high in IDLE, rsp_valid 2 cycles after accept, rsp_sum=0x0FFF, rsp_cout=0, rsp_id=0, cnt0=1.
REQ-032 Both valid from reset, req0 x=y=0xFFFF, req1 x=0x5555 y=0xAAAA -> req0 served first (rsp_sum=0xEFFF, rsp_cout=1), then req1 (rsp_sum=0xFFFF, rsp_cout=0); ids 0 then 1.
REQ-033 Both held valid for 6 transactions -> rsp_id sequence 0,1,0,1,0,1; cnt0=cnt1=3.
REQ-034 rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_sum/rsp_id stable, both req_ready low, add_x/add_y unchanged.
REQ-035 rst_n low during EXEC -> all outputs at reset values, no response issued, cnt unchanged at 0, next request served normally.
REQ-036 cnt0 preset to 0xFFFF via 65535 transactions (or forced) then one more -> cnt0=0x0000.
